// File: rtl/alu_serial.sv
// Bit-serial ALU sequencer: one alu_1bit slice iterated LSB-first over WIDTH cycles,
// with carry held between bits, followed by a single FINISH cycle that publishes flags.

module alu_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       bnegate,
  input  logic       less,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);
  logic aa, bb, sum;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ bnegate;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  // NOTE: a complete case (or a default assigned first) keeps combinational logic free of latches.
  always_comb begin
    unique case (op)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end
endmodule

module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, shreg;
  logic [3:0]       ctl_q;
  logic [CW-1:0]    cnt;
  logic             carry, cmsb, s_msb;
  logic             last;
  logic [1:0]       slice_op;
  logic             s_res, s_cout;
  logic             ov_n;
  logic [WIDTH-1:0] res_n;

  assign last     = (cnt == CW'(WIDTH-1));
  // SLT runs the slice as a subtract; the less-than bit is fixed up in FINISH.
  assign slice_op = (ctl_q[1:0] == 2'b11) ? 2'b10 : ctl_q[1:0];

  alu_1bit u_slice (
    .a       (a_q[cnt]),
    .b       (b_q[cnt]),
    .ainvert (ctl_q[3]),
    .bnegate (ctl_q[2]),
    .less    (1'b0),
    .cin     (carry),
    .op      (slice_op),
    .result  (s_res),
    .cout    (s_cout)
  );

  assign ov_n  = cmsb ^ carry;
  assign res_n = (ctl_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, s_msb ^ ov_n} : shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE:   if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      cnt      <= '0;
      shreg    <= '0;
      carry    <= 1'b0;
      cmsb     <= 1'b0;
      s_msb    <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          ctl_q <= alu_ctl;
          cnt   <= '0;
          shreg <= '0;
          carry <= alu_ctl[2];
        end
        RUN: begin
          carry <= s_cout;
          shreg <= {s_res, shreg[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (last) begin
            cmsb  <= carry;
            s_msb <= s_res;
          end
        end
        FINISH: begin
          overflow <= ov_n;
          result   <= res_n;
          zero     <= (res_n == '0);
        end
        default: ;
      endcase
    end
  end
endmodule
